// File: rtl/gf180mcu_fd_sc_mcu7t5v0__inv_pkg.sv
// Shared constants for the inverting pipeline: parameter defaults and the
// legal ranges checked at elaboration.
//   No ports.
package gf180mcu_fd_sc_mcu7t5v0__inv_pkg;

  localparam int INV_WIDTH_DEF = 8;
  localparam int INV_DEPTH_DEF = 2;

  localparam int INV_WIDTH_MIN = 1;
  localparam int INV_WIDTH_MAX = 64;
  localparam int INV_DEPTH_MIN = 1;
  localparam int INV_DEPTH_MAX = 8;

  // Polarity reset default: every bit inverts.
  localparam logic [INV_WIDTH_MAX-1:0] INV_POL_RST_DEF = '1;

  function automatic bit inv_params_ok(int width, int depth);
    return (width >= INV_WIDTH_MIN) && (width <= INV_WIDTH_MAX) &&
           (depth >= INV_DEPTH_MIN) && (depth <= INV_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__inv_pipe_if.sv
// Beat/handshake bundle of the inverting pipeline.
//   I, I_VALID, I_READY     : upstream beat handshake
//   POL, POL_LOAD           : polarity register load
//   ZN, ZN_VALID, ZN_READY  : downstream beat handshake
//   BUSY                    : any stage occupied
// Modport slave is the pipeline side, master the driver/consumer side.
interface gf180mcu_fd_sc_mcu7t5v0__inv_pipe_if
  import gf180mcu_fd_sc_mcu7t5v0__inv_pkg::*;
#(
  parameter int WIDTH = INV_WIDTH_DEF
);
  logic [WIDTH-1:0] I;
  logic             I_VALID;
  logic             I_READY;
  logic [WIDTH-1:0] POL;
  logic             POL_LOAD;
  logic [WIDTH-1:0] ZN;
  logic             ZN_VALID;
  logic             ZN_READY;
  logic             BUSY;

  modport slave (
    input  I, I_VALID, POL, POL_LOAD, ZN_READY,
    output I_READY, ZN, ZN_VALID, BUSY
  );

  modport master (
    output I, I_VALID, POL, POL_LOAD, ZN_READY,
    input  I_READY, ZN, ZN_VALID, BUSY
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__inv_pipe_stage.sv
// One valid-tagged pipeline register.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : upstream stage (or input port) holds a beat
//   in_data   : that beat
//   out_ready : downstream stage takes this stage's beat this cycle
//   valid     : this stage holds a beat
//   data      : the held beat
//   ready     : this stage loads this cycle (empty or advancing)
module gf180mcu_fd_sc_mcu7t5v0__inv_pipe_stage
  import gf180mcu_fd_sc_mcu7t5v0__inv_pkg::*;
#(
  parameter int WIDTH = INV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             valid,
  output logic             ready,
  output logic [WIDTH-1:0] data
);

  // Loading whenever empty or draining gives bubble collapse.
  assign ready = !valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= in_valid;
      // Data only moves with a real beat, keeping ZN quiet on bubbles.
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__inv_pipe.sv
// Configurable-polarity inverter pipeline: each accepted beat is XORed with
// the polarity register and carried through DEPTH valid/ready stages.
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : beat handshake, polarity load, BUSY (slave side)
module gf180mcu_fd_sc_mcu7t5v0__inv_pipe
  import gf180mcu_fd_sc_mcu7t5v0__inv_pkg::*;
#(
  parameter int               WIDTH   = INV_WIDTH_DEF,
  parameter int               DEPTH   = INV_DEPTH_DEF,
  parameter logic [WIDTH-1:0] POL_RST = INV_POL_RST_DEF[WIDTH-1:0]
) (
  input logic CLK,
  input logic RST,
  gf180mcu_fd_sc_mcu7t5v0__inv_pipe_if.slave bus
);

  if (!inv_params_ok(WIDTH, DEPTH)) begin : g_bad_params
    $error("inv_pipe: WIDTH=%0d DEPTH=%0d out of legal range", WIDTH, DEPTH);
  end

  logic [WIDTH-1:0]            pol_q;
  logic [DEPTH-1:0]            stg_valid;
  logic [DEPTH-1:0]            stg_ready;
  logic [DEPTH-1:0]            stg_in_valid;
  logic [DEPTH-1:0]            stg_out_ready;
  logic [DEPTH-1:0][WIDTH-1:0] stg_data;
  logic [DEPTH-1:0][WIDTH-1:0] stg_in_data;

  // A load on the accepting edge only affects later beats, because the
  // XOR below sees the pre-edge register value.
  always_ff @(posedge CLK) begin
    if (RST)               pol_q <= POL_RST;
    else if (bus.POL_LOAD) pol_q <= bus.POL;
  end

  assign stg_in_valid[0] = bus.I_VALID;
  assign stg_in_data[0]  = bus.I ^ pol_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k > 0) begin : g_chain
      assign stg_in_valid[k] = stg_valid[k-1];
      assign stg_in_data[k]  = stg_data[k-1];
    end
    if (k < DEPTH-1) begin : g_mid
      assign stg_out_ready[k] = stg_ready[k+1];
    end else begin : g_last
      assign stg_out_ready[k] = bus.ZN_READY;
    end

    gf180mcu_fd_sc_mcu7t5v0__inv_pipe_stage #(.WIDTH(WIDTH)) u_stg (
      .clk       (CLK),
      .rst       (RST),
      .in_valid  (stg_in_valid[k]),
      .in_data   (stg_in_data[k]),
      .out_ready (stg_out_ready[k]),
      .valid     (stg_valid[k]),
      .ready     (stg_ready[k]),
      .data      (stg_data[k])
    );
  end

  // Ready chain runs back from ZN_READY only; I_VALID never feeds I_READY.
  assign bus.I_READY  = stg_ready[0];
  assign bus.ZN       = stg_data[DEPTH-1];
  assign bus.ZN_VALID = stg_valid[DEPTH-1];
  assign bus.BUSY     = |stg_valid;

endmodule
